key_conditioner: RTL and testbench



---
 rtl/key_conditioner.sv | 148 ++++++++++++++
 tb/tb_key_conditioner.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Push-button conditioner: per-channel 2-FF synchronizer, debouncer, press/release
// pulses and optional hold-to-repeat pulse train, all outputs registered.
//
// Repeat FSM (one per channel):
//   state       | meaning
//   ST_IDLE     | key released, or repeat disabled
//   ST_DELAY    | key held, waiting REPEAT_DELAY cycles for the first repeat pulse
//   ST_PERIODIC | key held, pulsing every REPEAT_PERIOD cycles
module key_conditioner #(
   parameter int WIDTH           = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 0,
   parameter int REPEAT_PERIOD   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] key_n,
   output logic [WIDTH-1:0] key_level,
   output logic [WIDTH-1:0] key_press,
   output logic [WIDTH-1:0] key_release,
   output logic [WIDTH-1:0] key_repeat
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DELAY,
      ST_PERIODIC
   } rep_state_t;

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] DB_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam bit REP_EN = (REPEAT_DELAY > 0);
   localparam int R_MAX0 = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int R_MAX = (R_MAX0 < 1) ? 1 : R_MAX0;
   localparam int R_W = $clog2(R_MAX + 1);
   localparam logic [R_W-1:0] DLY_LOAD = R_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
   localparam logic [R_W-1:0] PER_LOAD = R_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("key_conditioner: DEBOUNCE_CYCLES must be >= 1");
   end
   if (REPEAT_DELAY > 0 && REPEAT_PERIOD < 1) begin : g_bad_period
      $error("key_conditioner: REPEAT_PERIOD must be >= 1 when repeat is enabled");
   end

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= ~key_n;
         sync2 <= sync1;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      logic [CNT_W-1:0] db_cnt_q;
      logic [CNT_W-1:0] db_cnt_d;
      logic             level_q;
      logic             level_d;
      logic             rise;
      logic             fall;
      logic             press_q;
      logic             release_q;
      logic             repeat_q;
      logic             repeat_d;
      rep_state_t       state_q;
      rep_state_t       state_d;
      logic [R_W-1:0]   rcnt_q;
      logic [R_W-1:0]   rcnt_d;

      // Any sample matching the accepted level restarts the stability run.
      always_comb begin
         db_cnt_d = db_cnt_q + CNT_W'(1);
         level_d  = level_q;
         if (sync2[i] == level_q) begin
            db_cnt_d = '0;
         end else if (db_cnt_q == DB_TC) begin
            level_d  = sync2[i];
            db_cnt_d = '0;
         end
      end

      assign rise = level_d & ~level_q;
      assign fall = ~level_d & level_q;

      // rcnt is a down-counter; a pulse is due when it reaches zero.
      always_comb begin
         state_d  = state_q;
         rcnt_d   = rcnt_q;
         repeat_d = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (rise && REP_EN) begin
                  state_d = ST_DELAY;
                  rcnt_d  = DLY_LOAD;
               end
            end
            ST_DELAY, ST_PERIODIC: begin
               if (fall) begin
                  state_d = ST_IDLE;
                  rcnt_d  = '0;
               end else if (rcnt_q == '0) begin
                  repeat_d = 1'b1;
                  state_d  = ST_PERIODIC;
                  rcnt_d   = PER_LOAD;
               end else begin
                  rcnt_d = rcnt_q - R_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               rcnt_d  = '0;
            end
         endcase
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            state_q   <= ST_IDLE;
            rcnt_q    <= '0;
         end else begin
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= rise;
            release_q <= fall;
            repeat_q  <= repeat_d;
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
         end
      end

      assign key_level[i]   = level_q;
      assign key_press[i]   = press_q;
      assign key_release[i] = release_q;
      assign key_repeat[i]  = repeat_q;
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: constant-expectation vector table,
// hand-written corner sequences, then randomized stimulus against a reference model.
module tb_key_conditioner;

   localparam int W  = 2;
   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] key_n = '1;
   logic [W-1:0] key_level;
   logic [W-1:0] key_press;
   logic [W-1:0] key_release;
   logic [W-1:0] key_repeat;

   int checks = 0;
   int errors = 0;

   key_conditioner #(
      .WIDTH(W),
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .key_n(key_n),
      .key_level(key_level),
      .key_press(key_press),
      .key_release(key_release),
      .key_repeat(key_repeat)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         rst;
      logic [W-1:0] key_n;
      logic [W-1:0] level;
      logic [W-1:0] press;
      logic [W-1:0] rel;
      logic [W-1:0] rep;
   } vec_t;

   vec_t tbl[$];

   // Reference model: delay line of two samples, a stable-run length per channel,
   // and the number of edges since the accepted press for the repeat schedule.
   bit           md1[W];
   bit           md2[W];
   bit           mlvl[W];
   int           mrun[W];
   int           msince[W];
   logic [W-1:0] mp = '0;
   logic [W-1:0] mr = '0;
   logic [W-1:0] mq = '0;

   task automatic model_edge(input logic r, input logic [W-1:0] kn);
      for (int c = 0; c < W; c++) begin
         bit seen;
         if (r) begin
            md1[c] = 1'b0; md2[c] = 1'b0; mlvl[c] = 1'b0;
            mrun[c] = 0; msince[c] = 0;
            mp[c] = 1'b0; mr[c] = 1'b0; mq[c] = 1'b0;
         end else begin
            seen   = md2[c];
            md2[c] = md1[c];
            md1[c] = ~kn[c];
            mp[c] = 1'b0; mr[c] = 1'b0; mq[c] = 1'b0;
            if (seen == mlvl[c]) begin
               mrun[c] = 0;
            end else begin
               mrun[c]++;
               if (mrun[c] == DB) begin
                  mlvl[c] = seen;
                  mrun[c] = 0;
                  if (seen) mp[c] = 1'b1;
                  else mr[c] = 1'b1;
               end
            end
            if (mp[c]) msince[c] = 0;
            else if (mlvl[c]) msince[c]++;
            mq[c] = mlvl[c] && !mp[c] && (msince[c] >= RD) && (((msince[c] - RD) % RP) == 0);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(rst, key_n);
      #1;
   endtask

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic add_row(input logic r, input logic [W-1:0] kn, input logic [W-1:0] lv,
                          input logic [W-1:0] pr, input logic [W-1:0] rl, input logic [W-1:0] rp);
      vec_t v;
      v.rst = r; v.key_n = kn; v.level = lv; v.press = pr; v.rel = rl; v.rep = rp;
      tbl.push_back(v);
   endtask

   task automatic do_reset(input int n);
      rst   = 1'b1;
      key_n = '1;
      repeat (n) step();
      rst = 1'b0;
   endtask

   initial begin
      int   press_cnt;
      logic slow;

      // 20 reset cycles, then ch1 pressed for edges 1..25 and released from edge 26.
      for (int e = 0; e < 20; e++) add_row(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
      for (int e = 1; e <= 35; e++) begin
         add_row(1'b0,
                 (e <= 25) ? 2'b01 : 2'b11,
                 (e >= 6 && e <= 30) ? 2'b10 : 2'b00,
                 (e == 6) ? 2'b10 : 2'b00,
                 (e == 31) ? 2'b10 : 2'b00,
                 (e == 16 || e == 19 || e == 22 || e == 25 || e == 28) ? 2'b10 : 2'b00);
      end

      foreach (tbl[k]) begin
         rst   = tbl[k].rst;
         key_n = tbl[k].key_n;
         step();
         check($sformatf("tbl%0d level", k), key_level, tbl[k].level);
         check($sformatf("tbl%0d press", k), key_press, tbl[k].press);
         check($sformatf("tbl%0d release", k), key_release, tbl[k].rel);
         check($sformatf("tbl%0d repeat", k), key_repeat, tbl[k].rep);
      end

      // Bounce on ch0: pressed, pressed, released, then pressed.
      do_reset(3);
      press_cnt = 0;
      for (int e = 1; e <= 14; e++) begin
         key_n = {1'b1, (e == 3)};
         step();
         if (key_press[0]) press_cnt++;
         check($sformatf("bounce e%0d level", e), key_level, {1'b0, (e >= 9)});
         check($sformatf("bounce e%0d press", e), key_press, {1'b0, (e == 9)});
      end
      check("bounce press count", 2'(press_cnt), 2'd1);

      // Three-cycle glitch never gets accepted.
      do_reset(3);
      for (int e = 1; e <= 14; e++) begin
         key_n = {1'b1, (e > 3)};
         step();
         check($sformatf("glitch e%0d level", e), key_level, 2'b00);
         check($sformatf("glitch e%0d press", e), key_press, 2'b00);
         check($sformatf("glitch e%0d release", e), key_release, 2'b00);
      end

      // Both channels pressed and released together.
      do_reset(3);
      for (int e = 1; e <= 16; e++) begin
         key_n = (e <= 8) ? 2'b00 : 2'b11;
         step();
         check($sformatf("simul e%0d press", e), key_press, (e == 6) ? 2'b11 : 2'b00);
         check($sformatf("simul e%0d release", e), key_release, (e == 14) ? 2'b11 : 2'b00);
         check($sformatf("simul e%0d repeat", e), key_repeat, 2'b00);
      end

      // Reset at edge 18 while ch0 is repeating; held key is a new press afterwards.
      do_reset(3);
      key_n = 2'b10;
      for (int e = 1; e <= 17; e++) begin
         step();
         check($sformatf("midrst e%0d repeat", e), key_repeat, (e == 16) ? 2'b01 : 2'b00);
      end
      rst = 1'b1;
      step();
      check("midrst e18 level", key_level, 2'b00);
      check("midrst e18 press", key_press, 2'b00);
      check("midrst e18 repeat", key_repeat, 2'b00);
      rst = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         step();
         check($sformatf("postrst e%0d level", e), key_level, {1'b0, (e >= 6)});
         check($sformatf("postrst e%0d press", e), key_press, {1'b0, (e == 6)});
      end

      // Randomized phases of chatter and long holds, with occasional resets.
      do_reset(3);
      slow = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         if (n % 64 == 0) slow = ($urandom_range(0, 2) != 0);
         for (int c = 0; c < W; c++) begin
            if ($urandom_range(0, slow ? 40 : 3) == 0) key_n[c] = ~key_n[c];
         end
         rst = ($urandom_range(0, 599) == 0);
         step();
         check($sformatf("rand%0d level", n), key_level, {mlvl[1], mlvl[0]});
         check($sformatf("rand%0d press", n), key_press, mp);
         check($sformatf("rand%0d release", n), key_release, mr);
         check($sformatf("rand%0d repeat", n), key_repeat, mq);
         check($sformatf("rand%0d press&release", n), key_press & key_release, 2'b00);
         check($sformatf("rand%0d repeat&~level", n), key_repeat & ~key_level, 2'b00);
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
